// File: rtl/en_dff_rr_arbiter.sv
// en_dff_rr_arbiter: one enabled data register shared by NUM_REQ requesters under round-robin arbitration.
module en_dff_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] INI_DATA = 32'h1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         iReq,
    input  logic [NUM_REQ*WIDTH-1:0]   iDat,
    output logic [NUM_REQ-1:0]         oAck,
    output logic                       oVld,
    input  logic                       iRdy,
    output logic [WIDTH-1:0]           oDat,
    output logic [$clog2(NUM_REQ)-1:0] oSrc
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] ptr, gnt, idx;
    logic          found, load;

    // First set request at or above ptr, wrapping to 0.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % NUM_REQ);
            if (!found && iReq[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    // Gating with rst keeps oAck low while reset is asserted.
    assign load = rst & found & ((state == EMPTY) | iRdy);
    assign oAck = load ? (NUM_REQ'(1) << gnt) : '0;

    always_comb begin
        state_nxt = load ? FULL : ((state == FULL) && iRdy) ? EMPTY : state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
            oVld  <= 1'b0;
            oDat  <= INI_DATA;
            oSrc  <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            oVld  <= (state_nxt == FULL);
            if (load) begin
                oDat <= iDat[int'(gnt)*WIDTH +: WIDTH];
                oSrc <= gnt;
                ptr  <= (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_en_dff_rr_arbiter.sv
// tb_en_dff_rr_arbiter: directed vector table plus randomized run against a distance-based round-robin model.
module tb_en_dff_rr_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   iReq, oAck;
    logic [N*W-1:0] iDat;
    logic           iRdy, oVld;
    logic [W-1:0]   oDat;
    logic [1:0]     oSrc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    en_dff_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .INI_DATA(32'h1)) dut (
        .clk(clk), .rst(rst), .iReq(iReq), .iDat(iDat), .oAck(oAck),
        .oVld(oVld), .iRdy(iRdy), .oDat(oDat), .oSrc(oSrc)
    );

    typedef struct {
        logic        r;
        logic [3:0]  req;
        logic        rdy;
        logic [3:0]  ack;
        logic        vld;
        logic [31:0] dat;
        logic [1:0]  src;
    } vec_t;

    vec_t vt[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: winner is the requester with the smallest forward distance from ptr.
    function automatic int pick(input logic [3:0] req, input int p);
        int best = -1;
        int bd = N;
        for (int i = 0; i < N; i++)
            if (req[i] && ((i - p + N) % N) < bd) begin
                bd = (i - p + N) % N;
                best = i;
            end
        return best;
    endfunction

    logic        m_vld;
    logic [31:0] m_dat;
    int          m_src, m_ptr;
    logic        pend[N];
    logic [31:0] pdat[N];
    int          waits[N];

    initial begin
        vt[0]  = '{1, 4'b0100, 0, 4'b0100, 0, 32'h0000_0001, 0};
        vt[1]  = '{1, 4'b0000, 0, 4'b0000, 1, 32'hA5A5_0002, 2};
        vt[2]  = '{0, 4'b1111, 1, 4'b0000, 0, 32'h0000_0001, 0};
        vt[3]  = '{1, 4'b1111, 1, 4'b0001, 0, 32'h0000_0001, 0};
        vt[4]  = '{1, 4'b1111, 1, 4'b0010, 1, 32'hA5A5_0300, 0};
        vt[5]  = '{1, 4'b1111, 1, 4'b0100, 1, 32'hA5A5_0401, 1};
        vt[6]  = '{1, 4'b1111, 1, 4'b1000, 1, 32'hA5A5_0502, 2};
        vt[7]  = '{1, 4'b1111, 1, 4'b0001, 1, 32'hA5A5_0603, 3};
        vt[8]  = '{1, 4'b0011, 0, 4'b0000, 1, 32'hA5A5_0700, 0};
        vt[9]  = '{1, 4'b0011, 0, 4'b0000, 1, 32'hA5A5_0700, 0};
        vt[10] = '{1, 4'b0011, 0, 4'b0000, 1, 32'hA5A5_0700, 0};
        vt[11] = '{1, 4'b0011, 0, 4'b0000, 1, 32'hA5A5_0700, 0};
        vt[12] = '{1, 4'b0011, 0, 4'b0000, 1, 32'hA5A5_0700, 0};
        vt[13] = '{1, 4'b0011, 1, 4'b0010, 1, 32'hA5A5_0700, 0};
        vt[14] = '{1, 4'b1000, 1, 4'b1000, 1, 32'hA5A5_0D01, 1};
        vt[15] = '{1, 4'b1001, 1, 4'b0001, 1, 32'hA5A5_0E03, 3};
        vt[16] = '{1, 4'b0000, 1, 4'b0000, 1, 32'hA5A5_0F00, 0};
        vt[17] = '{1, 4'b0000, 1, 4'b0000, 0, 32'hA5A5_0F00, 0};
        vt[18] = '{1, 4'b0100, 0, 4'b0100, 0, 32'hA5A5_0F00, 0};
        vt[19] = '{0, 4'b1111, 0, 4'b0000, 0, 32'h0000_0001, 0};
        vt[20] = '{1, 4'b1100, 0, 4'b0100, 0, 32'h0000_0001, 0};
        vt[21] = '{1, 4'b0000, 0, 4'b0000, 1, 32'hA5A5_1402, 2};

        rst = 1'b0; iReq = '0; iDat = '0; iRdy = 1'b0;
        @(negedge clk);
        @(negedge clk);

        for (int v = 0; v < 22; v++) begin
            rst = vt[v].r; iReq = vt[v].req; iRdy = vt[v].rdy;
            for (int i = 0; i < N; i++) iDat[i*W +: W] = {16'hA5A5, 8'(v), 8'(i)};
            #1;
            chk($sformatf("vec%0d ack", v), 32'(oAck), 32'(vt[v].ack));
            chk($sformatf("vec%0d vld", v), 32'(oVld), 32'(vt[v].vld));
            chk($sformatf("vec%0d dat", v), oDat, vt[v].dat);
            chk($sformatf("vec%0d src", v), 32'(oSrc), 32'(vt[v].src));
            @(posedge clk);
            @(negedge clk);
        end

        rst = 1'b0; iReq = '0;
        @(negedge clk);
        m_vld = 1'b0; m_dat = 32'h1; m_src = 0; m_ptr = 0;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pdat[i] = '0; waits[i] = 0; end

        for (int c = 0; c < 600; c++) begin
            logic [3:0] req;
            logic [3:0] exp_ack;
            logic       load;
            int         g;
            rst  = ($urandom_range(0, 59) != 0);
            iRdy = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    pdat[i] = $urandom;
                    waits[i] = 0;
                end
                req[i] = pend[i];
                iDat[i*W +: W] = pdat[i];
            end
            iReq = req;
            #1;
            if (!rst) begin
                m_vld = 1'b0; m_dat = 32'h1; m_src = 0; m_ptr = 0;
                for (int i = 0; i < N; i++) waits[i] = 0;
            end
            g = pick(req, m_ptr);
            load = rst && (req != 0) && (!m_vld || iRdy);
            exp_ack = load ? 4'(1 << g) : 4'b0000;
            chk("rnd ack", 32'(oAck), 32'(exp_ack));
            chk("rnd vld", 32'(oVld), 32'(m_vld));
            chk("rnd dat", oDat, m_dat);
            chk("rnd src", 32'(oSrc), 32'(m_src));
            if (load) begin
                chk("rnd fairness", 32'(waits[g] <= N - 1), 32'd1);
                for (int i = 0; i < N; i++) if (pend[i] && i != g) waits[i]++;
                pend[g] = 1'b0;
                m_dat = pdat[g]; m_src = g; m_ptr = (g + 1) % N; m_vld = 1'b1;
            end else if (m_vld && iRdy) begin
                m_vld = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
